// File: rtl/mux_sel_sched_if.sv
// Bus between the 8-channel scheduler, its requesters, the 11-bit 8:1 mux and the downstream consumer.
// Output handshake: a word transfers on a rising edge where out_valid and out_ready are both high;
// once out_valid rises it stays high and out_data stays stable until that transfer.
interface mux_sel_sched_if #(
   parameter int DATA_W = 11,
   parameter int NCH    = 8
);
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    ack;
   logic [2:0]        select;
   logic [DATA_W-1:0] mux_out;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  req, mux_out, out_ready,
      output ack, select, out_data, out_valid
   );

   modport master (
      output req, mux_out, out_ready,
      input  ack, select, out_data, out_valid
   );
endinterface

// File: rtl/mux_sel_sched.sv
// Round-robin scheduler driving an 8:1 mux select and capturing its result into a valid/ready output.
// Define MUX_SEL_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration (no rotating pointer).
module mux_sel_sched #(
   parameter int DATA_W = 11,
   parameter int NCH    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_sel_sched_if.slave    bus,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        select_q, select_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [NCH-1:0]    ack_q, ack_d;

   logic              win_vld;
   logic [2:0]        win_idx;

`ifdef MUX_SEL_SCHED_FIXED_PRIO_EN
   always_comb begin
      win_vld = 1'b0;
      win_idx = 3'd0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (bus.req[k]) begin
            win_vld = 1'b1;
            win_idx = 3'(k);
         end
      end
   end
`else
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] scan_idx;

   // Scan starts just after the last grant and wraps, so ptr itself is considered last.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = 3'd0;
      scan_idx = 3'd0;
      for (int k = 1; k <= NCH; k++) begin
         scan_idx = ptr_q + 3'(k);
         if (!win_vld && bus.req[scan_idx]) begin
            win_vld = 1'b1;
            win_idx = scan_idx;
         end
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      select_d    = select_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ack_d       = '0;
`ifndef MUX_SEL_SCHED_FIXED_PRIO_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               select_d = win_idx;
               state_d  = ST_SEL;
            end
         end
         ST_SEL: begin
            // select has been stable for a full cycle, so the mux result is settled here.
            out_data_d      = bus.mux_out;
            out_valid_d     = 1'b1;
            ack_d[select_q] = 1'b1;
`ifndef MUX_SEL_SCHED_FIXED_PRIO_EN
            ptr_d           = select_q;
`endif
            state_d         = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (win_vld) begin
                  select_d = win_idx;
                  state_d  = ST_SEL;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         select_q    <= 3'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ack_q       <= '0;
`ifndef MUX_SEL_SCHED_FIXED_PRIO_EN
         ptr_q       <= 3'd7;
`endif
      end else begin
         state_q     <= state_d;
         select_q    <= select_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ack_q       <= ack_d;
`ifndef MUX_SEL_SCHED_FIXED_PRIO_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus.select    = select_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ack       = ack_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mux_sel_sched.sv
// Directed bench for mux_sel_sched: the bench models the external 8:1 mux and checks the scheduler outputs.
module tb_mux_sel_sched;

   localparam int DATA_W = 11;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEL  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic              clk;
   logic              rst_n;
   logic [1:0]        dbg_state;
   logic [DATA_W-1:0] chan_data [8];
   logic [DATA_W-1:0] mux_noise;
   int                n_vec;
   int                n_err;

   mux_sel_sched_if #(.DATA_W(DATA_W), .NCH(8)) bus ();

   mux_sel_sched #(.DATA_W(DATA_W), .NCH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // External mux model; noise lets the bench disturb mux_out outside the capture cycle.
   assign bus.mux_out = chan_data[bus.select] ^ mux_noise;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int grant_seq [5];
      n_vec = 0;
      n_err = 0;
      chan_data[0] = 11'h101;
      chan_data[1] = 11'h2B2;
      chan_data[2] = 11'h0C3;
      chan_data[3] = 11'h3D4;
      chan_data[4] = 11'h4E5;
      chan_data[5] = 11'h5A3;
      chan_data[6] = 11'h6F7;
      chan_data[7] = 11'h7A8;
      mux_noise     = '0;
      rst_n         = 1'b0;
      bus.req       = 8'hFF;
      bus.out_ready = 1'b1;

      // Reset held for two cycles with all requests up.
      step();
      step();
      chk("rst_select", 32'(bus.select), 32'd0);
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_data",   32'(bus.out_data), 32'd0);
      chk("rst_ack",    32'(bus.ack), 32'd0);
      chk("rst_state",  32'(dbg_state), 32'(S_IDLE));

      // Round-robin with req = 91 held and out_ready high.
`ifdef MUX_SEL_SCHED_FIXED_PRIO_EN
      grant_seq = '{0, 0, 0, 0, 0};
`else
      grant_seq = '{0, 4, 7, 0, 4};
`endif
      rst_n   = 1'b1;
      bus.req = 8'h91;
      for (int g = 0; g < 5; g++) begin
         step();
         chk("rr_select", 32'(bus.select), 32'(grant_seq[g]));
         chk("rr_sel_state", 32'(dbg_state), 32'(S_SEL));
         chk("rr_sel_valid", 32'(bus.out_valid), 32'd0);
         step();
         chk("rr_ack", 32'(bus.ack), 32'd1 << grant_seq[g]);
         chk("rr_valid", 32'(bus.out_valid), 32'd1);
         chk("rr_data", 32'(bus.out_data), 32'(chan_data[grant_seq[g]]));
      end

      // Backpressure: word from the last grant must hold while mux_out churns.
      bus.req       = 8'h00;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         mux_noise = 11'($urandom_range(1, 2047));
         step();
         chk("bp_data",   32'(bus.out_data), 32'(chan_data[grant_seq[4]]));
         chk("bp_select", 32'(bus.select), 32'(grant_seq[4]));
         chk("bp_ack",    32'(bus.ack), 32'd0);
         chk("bp_valid",  32'(bus.out_valid), 32'd1);
      end
      mux_noise     = '0;
      bus.out_ready = 1'b1;
      step();
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'(S_IDLE));

      // Single channel 5, then drop the request and complete the handshake.
      bus.req = 8'h20;
      step();
      chk("single_select", 32'(bus.select), 32'd5);
      step();
      chk("single_data",  32'(bus.out_data), 32'h5A3);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_ack",   32'(bus.ack), 32'h20);
      bus.req = 8'h00;
      step();
      chk("single_ack_clear", 32'(bus.ack), 32'd0);
      chk("single_idle_valid", 32'(bus.out_valid), 32'd0);
      chk("single_idle_state", 32'(dbg_state), 32'(S_IDLE));

      // Idle restart with channel 1.
      bus.req = 8'h02;
      step();
      chk("idle_new_select", 32'(bus.select), 32'd1);
      bus.out_ready = 1'b0;
      step();
      bus.req = 8'h00;
      chk("idle_new_ack",   32'(bus.ack), 32'h02);
      chk("idle_new_valid", 32'(bus.out_valid), 32'd1);
      chk("idle_new_data",  32'(bus.out_data), 32'(chan_data[1]));

      // Reset while the word sits in OUT: word is dropped, pointer restored to 7.
      rst_n = 1'b0;
      step();
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_ack",   32'(bus.ack), 32'd0);
      chk("mid_rst_data",  32'(bus.out_data), 32'd0);
      chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst_n         = 1'b1;
      bus.req       = 8'h22;
      bus.out_ready = 1'b1;
      step();
      chk("post_rst_select", 32'(bus.select), 32'd1);
      bus.req = 8'h00;
      step();
      chk("post_rst_ack", 32'(bus.ack), 32'h02);
      chk("post_rst_data", 32'(bus.out_data), 32'(chan_data[1]));
      step();
      chk("post_rst_ack_clear", 32'(bus.ack), 32'd0);
      chk("post_rst_idle", 32'(dbg_state), 32'(S_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
